// File: rtl/cayde_pkg.sv
// Shared types for the cayde execute-stage ALU: op codes, FSM states and op helpers.
package cayde_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/cayde_alu_comb.sv
// Single-cycle ALU ops; shifts and unknown codes yield zero here.
module cayde_alu_comb
  import cayde_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c
);

  always_comb begin
    result_c = '0;
    unique case (op)
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_ADD:  result_c = a + b;
      ALU_XOR:  result_c = a ^ b;
      ALU_SUB:  result_c = a - b;
      ALU_SLT:  result_c = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result_c = XLEN'(a < b);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/cayde_alu_seq.sv
// Multi-cycle ALU: one-cycle logic/arith/compare ops, bit-serial shifts,
// valid/ready on both sides with a held result until the consumer drains it.
module cayde_alu_seq
  import cayde_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  alu_state_t      state_q, state_d;
  alu_op_t         op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  alu_op_t         op_in;
  logic [SHW-1:0]  shamt_in;
  logic            accept;
  logic [XLEN-1:0] comb_res;
  logic [XLEN-1:0] shifted;

  assign op_in    = alu_op_t'(op);
  assign shamt_in = b[SHW-1:0];
  assign accept   = in_valid && in_ready_q;

  cayde_alu_comb #(.XLEN(XLEN)) u_comb (
    .op       (op_in),
    .a        (a),
    .b        (b),
    .result_c (comb_res)
  );

  // One-bit step of the shift accumulator for the captured op
  always_comb begin
    shifted = acc_q;
    case (op_q)
      ALU_SLL: shifted = {acc_q[XLEN-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, acc_q[XLEN-1:1]};
      ALU_SRA: shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: shifted = acc_q;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= ALU_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (is_shift(op_in) && (shamt_in != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and registered handshake flags derived from next state
  always_comb begin
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = op_in;
          if (is_shift(op_in) && (shamt_in != '0)) begin
            acc_d = a;
            cnt_d = shamt_in;
          end else if (is_shift(op_in)) begin
            result_d = a;
            zero_d   = (a == '0);
          end else begin
            result_d = comb_res;
            zero_d   = (comb_res == '0);
          end
        end
      end
      SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cayde_alu_seq.sv
// Directed self-checking bench for cayde_alu_seq with hand-computed expectations.
module tb_cayde_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cayde_alu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for one accepting edge; returns at the first cycle after accept.
  task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
    step();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0000_0003;
  endtask

  // Issue, wait (bounded) for out_valid, check latency/result/zero, then drain.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_res,
                        input int exp_lat);
    int lat;
    issue(o, va, vb);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    step();
    chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = 4'b0000;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    step();
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    run_op("add_zero", 4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1);
    run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    run_op("sltu", 4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    run_op("or", 4'b0001, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1);
    run_op("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    run_op("sub_wrap", 4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    run_op("bad_op", 4'b0100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1);

    // Long shift: check busy/SHIFT occupancy part way through
    issue(4'b1011, 32'h8000_0000, 32'd31);
    chk("sra_busy", {31'd0, busy}, 32'd1);
    chk("sra_in_ready", {31'd0, in_ready}, 32'd0);
    chk("sra_no_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 2; i <= 31; i++) step();
    chk("sra_c31_no_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("sra_c32_valid", {31'd0, out_valid}, 32'd1);
    chk("sra_res", result, 32'hFFFF_FFFF);
    step();
    chk("sra_drain", {31'd0, in_ready}, 32'd1);

    run_op("srl31", 4'b1010, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_op("sll4", 4'b1001, 32'h0000_0001, 32'd4, 32'h0000_0010, 5);
    run_op("sll_sh0", 4'b1001, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1);
    run_op("srl_out", 4'b1010, 32'h0000_0001, 32'd1, 32'h0000_0000, 2);

    // Backpressure: result held, new requests ignored
    out_ready = 1'b0;
    issue(4'b0110, 32'd10, 32'd3);
    in_valid = 1'b1;
    op = 4'b0010;
    a = 32'd100;
    b = 32'd200;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, 32'd7);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);
    step();
    chk("bp_no_ghost", {31'd0, out_valid}, 32'd0);

    // Reset mid-shift aborts the op
    issue(4'b1001, 32'h0000_0001, 32'd20);
    for (int i = 2; i <= 5; i++) step();
    chk("rs_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_result", result, 32'd0);
    chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rs_busy_clr", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 20; i++) step();
    chk("rs_no_result", {31'd0, out_valid}, 32'd0);
    run_op("post_rst_add", 4'b0010, 32'd2, 32'd2, 32'd4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
